uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_pkg.sv | 24 ++
 rtl/uart_rx_ctrl_sync_fifo.sv | 58 +++++
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive controller.
`default_nettype none

package uart_rx_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Increment v, saturating at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; head word reads as zero when empty.
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot this edge, so a full FIFO can still take a push.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receiver enable FSM, receive FIFO, sticky overflow and error counters.
// Error counters exist only when UART_RX_CTRL_ERR_CNT_EN is defined.
`default_nettype none

module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int RESYNC_CYC = 32,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_en,
  input  logic                       clr,
  input  logic [BYTE_W-1:0]          rx_d,
  input  logic                       rx_valid,
  input  logic                       rx_parity_err,
  input  logic                       rx_frame_err,
  output logic                       rx_enable,
  output logic [BYTE_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           err_parity_cnt,
  output logic [CNT_W-1:0]           err_frame_cnt
);

  localparam int RC_W = $clog2(RESYNC_CYC+1);

  state_e          state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            overflow_q, overflow_d;
  logic            in_run, push, pop, fifo_full, fifo_empty;

  assign in_run = (state_q == ST_RUN);
  assign push   = in_run & rx_valid & ~rx_parity_err & ~rx_frame_err;
  assign pop    = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    case (state_q)
      ST_OFF: if (rx_en) state_d = ST_RUN;
      ST_RUN: begin
        // Disable wins over a simultaneous frame error.
        if (!rx_en) begin
          state_d = ST_STOP;
        end else if (rx_valid && rx_frame_err) begin
          state_d = ST_RESYNC;
          rc_d    = '0;
        end
      end
      ST_RESYNC: begin
        if (rc_q == RC_W'(RESYNC_CYC - 1)) begin
          rc_d    = '0;
          state_d = rx_en ? ST_RUN : ST_STOP;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_en)           state_d = ST_RUN;
        else if (fifo_empty) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clr)                           overflow_d = 1'b0;
    else if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      rc_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      overflow_q <= overflow_d;
    end
  end

  assign rx_enable = in_run;
  assign overflow  = overflow_q;
  assign m_valid   = ~fifo_empty;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (rx_d),
    .pop_i   (pop),
    .dout_o  (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

`ifdef UART_RX_CTRL_ERR_CNT_EN
  logic [CNT_W-1:0] par_cnt_q, par_cnt_d, frm_cnt_q, frm_cnt_d;

  always_comb begin
    par_cnt_d = par_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (clr) begin
      par_cnt_d = '0;
      frm_cnt_d = '0;
    end else if (in_run && rx_valid) begin
      if (rx_parity_err) par_cnt_d = CNT_W'(sat_inc(32'(par_cnt_q), CNT_W));
      if (rx_frame_err)  frm_cnt_d = CNT_W'(sat_inc(32'(frm_cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      par_cnt_q <= par_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign err_parity_cnt = par_cnt_q;
  assign err_frame_cnt  = frm_cnt_q;
`else
  assign err_parity_cnt = '0;
  assign err_frame_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic against a queue-based reference model.
`default_nettype none

module tb_uart_rx_ctrl;

`ifdef UART_RX_CTRL_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int RESYNC = 32;
  localparam int M_OFF = 0, M_RUN = 1, M_RESYNC = 2, M_STOP = 3;

  logic       clk = 1'b0;
  logic       rst_n, rx_en, clr, rx_valid, rx_parity_err, rx_frame_err, m_ready;
  logic [7:0] rx_d;

  logic       rx_enable, m_valid, overflow;
  logic [7:0] m_data, par8, frm8;
  logic [2:0] level;
  logic       rx_enable2, m_valid2, overflow2;
  logic [7:0] m_data2;
  logic [2:0] level2;
  logic [1:0] par2, frm2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] mq[$];
  int mode, resync_left, cp8, cf8, cp2, cf2;
  bit ovf;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .RESYNC_CYC(RESYNC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .clr(clr), .rx_d(rx_d),
    .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_enable(rx_enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .overflow(overflow), .err_parity_cnt(par8), .err_frame_cnt(frm8)
  );

  uart_rx_ctrl #(.DEPTH(DEPTH), .RESYNC_CYC(RESYNC), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .clr(clr), .rx_d(rx_d),
    .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_enable(rx_enable2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
    .level(level2), .overflow(overflow2), .err_parity_cnt(par2), .err_frame_cnt(frm2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input int w);
    return (c + 1 > (1 << w) - 1) ? (1 << w) - 1 : c + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    mode = M_OFF; resync_left = 0; ovf = 0;
    cp8 = 0; cf8 = 0; cp2 = 0; cf2 = 0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs present at that edge.
  task automatic model_edge();
    int sz;
    bit run, pop, good;
    sz   = mq.size();
    run  = (mode == M_RUN);
    pop  = (sz > 0) && m_ready;
    good = run && rx_valid && !rx_parity_err && !rx_frame_err;
    if (clr) begin
      cp8 = 0; cf8 = 0; cp2 = 0; cf2 = 0; ovf = 0;
    end else begin
      if (run && rx_valid && rx_parity_err) begin cp8 = sat(cp8, 8); cp2 = sat(cp2, 2); end
      if (run && rx_valid && rx_frame_err)  begin cf8 = sat(cf8, 8); cf2 = sat(cf2, 2); end
      if (good && sz == DEPTH && !pop) ovf = 1;
    end
    if (pop) void'(mq.pop_front());
    if (good && (sz < DEPTH || pop)) mq.push_back(rx_d);
    case (mode)
      M_OFF: if (rx_en) mode = M_RUN;
      M_RUN: begin
        if (!rx_en) mode = M_STOP;
        else if (rx_valid && rx_frame_err) begin mode = M_RESYNC; resync_left = RESYNC; end
      end
      M_RESYNC: begin
        resync_left--;
        if (resync_left == 0) mode = rx_en ? M_RUN : M_STOP;
      end
      default: begin
        if (rx_en) mode = M_RUN;
        else if (sz == 0) mode = M_OFF;
      end
    endcase
  endtask

  task automatic check_all();
    logic [31:0] ed;
    ed = (mq.size() > 0) ? 32'(mq[0]) : 32'd0;
    chk("rx_enable", 32'(rx_enable), 32'(mode == M_RUN));
    chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
    chk("m_data", 32'(m_data), ed);
    chk("level", 32'(level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("par_cnt", 32'(par8), CNT_EN ? 32'(cp8) : 32'd0);
    chk("frm_cnt", 32'(frm8), CNT_EN ? 32'(cf8) : 32'd0);
    chk("rx_enable2", 32'(rx_enable2), 32'(mode == M_RUN));
    chk("m_data2", 32'(m_data2), ed);
    chk("m_valid2", 32'(m_valid2), 32'(mq.size() > 0));
    chk("level2", 32'(level2), 32'(mq.size()));
    chk("overflow2", 32'(overflow2), 32'(ovf));
    chk("par_cnt2", 32'(par2), CNT_EN ? 32'(cp2) : 32'd0);
    chk("frm_cnt2", 32'(frm2), CNT_EN ? 32'(cf2) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic fe);
    rx_d = b; rx_valid = 1'b1; rx_parity_err = pe; rx_frame_err = fe;
    step();
    rx_valid = 1'b0; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && !rx_enable; i++) step();
    chk("wait_run", 32'(rx_enable), 32'd1);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 8 && m_valid; i++) step();
    chk("drain", 32'(level), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b[4];
    logic [7:0] nb;
    logic [7:0] exp_q[4];
    int off_cyc;

    rst_n = 1'b0; rx_en = 1'b1; clr = 1'b0; rx_d = 8'h00;
    rx_valid = 1'b0; rx_parity_err = 1'b0; rx_frame_err = 1'b0; m_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_m_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check_all();

    // Enable, one good byte
    step();
    chk("run_after_release", 32'(rx_enable), 32'd1);
    send(8'h55, 1'b0, 1'b0);
    chk("first_byte", 32'(m_data), 32'h55);
    chk("first_level", 32'(level), 32'd1);
    drain();

    // Overflow and pop order
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", 32'(m_data), 32'(i + 1));
      step();
    end
    m_ready = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;

    // Push while full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      send(b[i], 1'b0, 1'b0);
    end
    nb = 8'($urandom);
    m_ready = 1'b1;
    send(nb, 1'b0, 1'b0);
    chk("full_push_pop_level", 32'(level), 32'd4);
    chk("full_push_pop_ovf", 32'(overflow), 32'd0);
    exp_q[0] = b[1]; exp_q[1] = b[2]; exp_q[2] = b[3]; exp_q[3] = nb;
    for (int i = 0; i < 4; i++) begin
      chk("full_pop_order", 32'(m_data), 32'(exp_q[i]));
      step();
    end
    m_ready = 1'b0;

    // Frame error and resync hold-off
    clr = 1'b1; step(); clr = 1'b0;
    send(8'($urandom), 1'b0, 1'b1);
    chk("frame_cnt", 32'(frm8), CNT_EN ? 32'd1 : 32'd0);
    off_cyc = rx_enable ? 0 : 1;
    for (int i = 0; i < 40 && !rx_enable; i++) begin
      if (i == 4) begin rx_valid = 1'b1; rx_d = 8'hA5; end
      step();
      rx_valid = 1'b0;
      if (!rx_enable) off_cyc++;
    end
    chk("resync_len", 32'(off_cyc), 32'd32);
    chk("resync_drop", 32'(level), 32'd0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      rx_valid      = 1'($urandom_range(0, 1));
      rx_d          = 8'($urandom);
      rx_parity_err = ($urandom_range(0, 7) == 0);
      rx_frame_err  = ($urandom_range(0, 15) == 0);
      m_ready       = 1'($urandom_range(0, 1));
      rx_en         = ($urandom_range(0, 15) != 0);
      clr           = ($urandom_range(0, 31) == 0);
      step();
    end
    rx_valid = 1'b0; rx_parity_err = 1'b0; rx_frame_err = 1'b0; clr = 1'b0; rx_en = 1'b1;
    drain();
    wait_run();

    // Counter saturation on the 2-bit instance, then clear
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b1, 1'b0);
    chk("sat_par2", 32'(par2), CNT_EN ? 32'd3 : 32'd0);
    chk("sat_par8", 32'(par8), CNT_EN ? 32'd6 : 32'd0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_par2", 32'(par2), 32'd0);
    chk("clr_level", 32'(level), 32'd0);

    // Disable with bytes queued, drain through STOP to OFF
    send(8'($urandom), 1'b0, 1'b0);
    send(8'($urandom), 1'b0, 1'b0);
    rx_en = 1'b0;
    step();
    chk("stop_rx_enable", 32'(rx_enable), 32'd0);
    chk("stop_level", 32'(level), 32'd2);
    m_ready = 1'b1;
    step(); step();
    chk("stop_drained", 32'(level), 32'd0);
    step();
    m_ready = 1'b0;

    // Reset asserted mid-RESYNC
    rx_en = 1'b1;
    step();
    send(8'($urandom), 1'b1, 1'b1);
    repeat (5) step();
    chk("in_resync", 32'(rx_enable), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    #1;
    chk("off_after_release", 32'(rx_enable), 32'd0);
    step();
    chk("run_after_reset", 32'(rx_enable), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
